inst_fifo: RTL and testbench

//  Instruction queue between fetch and dual-issue decode. Fetch pushes 0-2 {pc,inst} per cycle.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/inst_fifo_mem.sv | 33 +++
 rtl/inst_fifo.sv | 119 +++++++++++
 tb/tb_inst_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: the {pc,inst} entry carried from fetch to decode
// and the default instruction queue depth.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W      = 32;
  localparam int unsigned INST_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] pc;
    logic [CPU_DATA_W-1:0] inst;
  } inst_entry_t;

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction queue storage: DEPTH entries, two write ports, two asynchronous
// read ports. Contents are never reset.
module inst_fifo_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = INST_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  inst_entry_t       wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  inst_entry_t       wdata1,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output inst_entry_t       rdata0,
  output inst_entry_t       rdata1
);

  inst_entry_t mem [DEPTH];

  // Port 1 always targets the slot after port 0, so the two never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction queue between fetch and dual-issue decode.
// Define INST_FIFO_PERF_EN to include saturating empty/full cycle counters.
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = INST_FIFO_DEPTH,
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push0_valid,
  input  logic [DATA_W-1:0]        push0_pc,
  input  logic [DATA_W-1:0]        push0_inst,
  input  logic                     push1_valid,
  input  logic [DATA_W-1:0]        push1_pc,
  input  logic [DATA_W-1:0]        push1_inst,
  input  logic                     pop_master,
  input  logic                     pop_slave,
  output logic                     master_valid,
  output logic [DATA_W-1:0]        master_pc,
  output logic [DATA_W-1:0]        master_inst,
  output logic                     slave_valid,
  output logic [DATA_W-1:0]        slave_pc,
  output logic [DATA_W-1:0]        slave_inst,
  output logic                     fifo_empty,
  output logic                     fifo_almost_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              perf_empty_cyc,
  output logic [31:0]              perf_full_cyc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          push_acc, push_two, pop_m, pop_s;
  logic [1:0]    n_push, n_pop;
  inst_entry_t   wdata0, wdata1, rdata0, rdata1;

  assign fifo_empty        = (cnt == '0);
  assign fifo_almost_empty = (cnt == CW'(1));
  assign fifo_full         = (cnt >= CW'(DEPTH - 1));
  assign master_valid      = (cnt >= CW'(1));
  assign slave_valid       = (cnt >= CW'(2));
  assign count             = cnt;

  // Acceptance and legality are judged on the registered count only.
  assign push_acc = push0_valid && !fifo_full;
  assign push_two = push_acc && push1_valid;
  assign pop_m    = pop_master && master_valid;
  assign pop_s    = pop_m && pop_slave && slave_valid;
  assign n_push   = {push_two, push_acc && !push_two};
  assign n_pop    = {pop_s, pop_m && !pop_s};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(n_pop);
      cnt    <= cnt + CW'(n_push) - CW'(n_pop);
    end
  end

  assign wdata0 = '{pc: push0_pc, inst: push0_inst};
  assign wdata1 = '{pc: push1_pc, inst: push1_inst};

  inst_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we0    (push_acc && resetn && !flush),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (push_two && resetn && !flush),
    .waddr1 (wr_ptr + AW'(1)),
    .wdata1 (wdata1),
    .raddr0 (rd_ptr),
    .raddr1 (rd_ptr + AW'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign master_pc   = master_valid ? rdata0.pc   : '0;
  assign master_inst = master_valid ? rdata0.inst : '0;
  assign slave_pc    = slave_valid  ? rdata1.pc   : '0;
  assign slave_inst  = slave_valid  ? rdata1.inst : '0;

`ifdef INST_FIFO_PERF_EN
  logic [31:0] empty_cyc, full_cyc;

  // Cleared only by reset so flush-heavy code still shows its starvation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      empty_cyc <= '0;
      full_cyc  <= '0;
    end else begin
      if (fifo_empty && (empty_cyc != '1)) empty_cyc <= empty_cyc + 32'd1;
      if (fifo_full  && (full_cyc  != '1)) full_cyc  <= full_cyc  + 32'd1;
    end
  end

  assign perf_empty_cyc = empty_cyc;
  assign perf_full_cyc  = full_cyc;
`else
  assign perf_empty_cyc = '0;
  assign perf_full_cyc  = '0;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: queue-based reference model with a
// per-cycle scoreboard, a count table, and hand-written corner sequences.
module tb_inst_fifo;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 32;

  logic          clk, resetn, flush;
  logic          push0_valid, push1_valid, pop_master, pop_slave;
  logic [DW-1:0] push0_pc, push0_inst, push1_pc, push1_inst;
  logic          master_valid, slave_valid;
  logic [DW-1:0] master_pc, master_inst, slave_pc, slave_inst;
  logic          fifo_empty, fifo_almost_empty, fifo_full;
  logic [4:0]    count;
  logic [31:0]   perf_empty_cyc, perf_full_cyc;

  inst_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .flush             (flush),
    .push0_valid       (push0_valid),
    .push0_pc          (push0_pc),
    .push0_inst        (push0_inst),
    .push1_valid       (push1_valid),
    .push1_pc          (push1_pc),
    .push1_inst        (push1_inst),
    .pop_master        (pop_master),
    .pop_slave         (pop_slave),
    .master_valid      (master_valid),
    .master_pc         (master_pc),
    .master_inst       (master_inst),
    .slave_valid       (slave_valid),
    .slave_pc          (slave_pc),
    .slave_inst        (slave_inst),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_full         (fifo_full),
    .count             (count),
    .perf_empty_cyc    (perf_empty_cyc),
    .perf_full_cyc     (perf_full_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  inst_entry_t mq[$];
  logic [31:0] m_pe, m_pf;
  logic [31:0] next_pc;

  typedef struct {
    logic p0, p1, pm, ps, fl;
    int   exp_count;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = mq.size();
    chk("count",        count, 64'(n));
    chk("empty",        fifo_empty, n == 0);
    chk("almost_empty", fifo_almost_empty, n == 1);
    chk("full",         fifo_full, n >= DEPTH - 1);
    chk("master_valid", master_valid, n >= 1);
    chk("master_pc",    master_pc,   (n >= 1) ? mq[0].pc   : 32'h0);
    chk("master_inst",  master_inst, (n >= 1) ? mq[0].inst : 32'h0);
    chk("slave_valid",  slave_valid, n >= 2);
    chk("slave_pc",     slave_pc,    (n >= 2) ? mq[1].pc   : 32'h0);
    chk("slave_inst",   slave_inst,  (n >= 2) ? mq[1].inst : 32'h0);
`ifdef INST_FIFO_PERF_EN
    chk("perf_empty",   perf_empty_cyc, m_pe);
    chk("perf_full",    perf_full_cyc,  m_pf);
`else
    chk("perf_empty",   perf_empty_cyc, 32'h0);
    chk("perf_full",    perf_full_cyc,  32'h0);
`endif
  endtask

  // Called at posedge+1; checks mid-cycle, advances the model at the edge.
  task automatic step(input logic p0, input logic p1, input logic pm, input logic ps,
                      input logic fl, input inst_entry_t e0, input inst_entry_t e1);
    int   n;
    logic full, popm, pops;
    push0_valid = p0; push0_pc = e0.pc; push0_inst = e0.inst;
    push1_valid = p1; push1_pc = e1.pc; push1_inst = e1.inst;
    pop_master  = pm; pop_slave = ps; flush = fl;
    #3;
    check_outputs();
    n    = mq.size();
    full = (n >= DEPTH - 1);
    if (n == 0 && m_pe != '1) m_pe++;
    if (full && m_pf != '1) m_pf++;
    if (fl) mq.delete();
    else begin
      popm = pm && (n >= 1);
      pops = popm && ps && (n >= 2);
      if (popm) void'(mq.pop_front());
      if (pops) void'(mq.pop_front());
      if (p0 && !full) begin
        mq.push_back(e0);
        if (p1) mq.push_back(e1);
      end
    end
    @(posedge clk);
    #1;
    push0_valid = 1'b0; push1_valid = 1'b0;
    pop_master  = 1'b0; pop_slave   = 1'b0; flush = 1'b0;
  endtask

  task automatic stepa(input logic p0, input logic p1, input logic pm, input logic ps, input logic fl);
    inst_entry_t e0, e1;
    logic acc;
    e0  = '{pc: next_pc,         inst: ~next_pc};
    e1  = '{pc: next_pc + 32'd4, inst: ~(next_pc + 32'd4)};
    acc = p0 && !fl && (mq.size() < DEPTH - 1);
    step(p0, p1, pm, ps, fl, e0, e1);
    if (acc) next_pc = next_pc + (p1 ? 32'd8 : 32'd4);
  endtask

  initial begin : main
    logic [31:0] last, save_pe, save_pf;
    bit          have_last;
    inst_entry_t e0, e1;

    resetn = 1'b0; flush = 1'b1;
    push0_valid = 1'b1; push0_pc = 32'hDEAD0000; push0_inst = 32'hDEADBEEF;
    push1_valid = 1'b1; push1_pc = 32'hDEAD0004; push1_inst = 32'hDEADBEEF;
    pop_master = 1'b1; pop_slave = 1'b1;
    m_pe = '0; m_pf = '0;
    next_pc = 32'hBFC00008;

    // Reset held two cycles with everything else asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",        fifo_empty, 1'b1);
    chk("rst_count",        count, 5'd0);
    chk("rst_master_valid", master_valid, 1'b0);
    chk("rst_master_pc",    master_pc, 32'h0);
    resetn = 1'b1; flush = 1'b0;
    push0_valid = 1'b0; push1_valid = 1'b0; pop_master = 1'b0; pop_slave = 1'b0;

    // Dual push, visible next cycle only
    e0 = '{pc: 32'hBFC00000, inst: 32'h11111111};
    e1 = '{pc: 32'hBFC00004, inst: 32'h22222222};
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e0, e1);
    chk("t2_count",        count, 5'd2);
    chk("t2_master_pc",    master_pc, 32'hBFC00000);
    chk("t2_slave_inst",   slave_inst, 32'h22222222);
    chk("t2_empty",        fifo_empty, 1'b0);
    chk("t2_almost_empty", fifo_almost_empty, 1'b0);

    // Single pop
    stepa(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_count",        count, 5'd1);
    chk("t3_almost_empty", fifo_almost_empty, 1'b1);
    chk("t3_master_pc",    master_pc, 32'hBFC00004);
    chk("t3_slave_valid",  slave_valid, 1'b0);

    // Count table: fill to full, boundary pushes/pops, drain, illegal requests
    for (int i = 0; i < 7; i++) tbl.push_back('{1, 1, 0, 0, 0, 3 + 2 * i});
    tbl.push_back('{1, 1, 0, 0, 0, 15});
    tbl.push_back('{1, 0, 0, 0, 0, 15});
    tbl.push_back('{0, 0, 1, 0, 0, 14});
    tbl.push_back('{1, 1, 1, 1, 0, 14});
    tbl.push_back('{1, 1, 0, 0, 0, 16});
    tbl.push_back('{1, 1, 1, 0, 0, 15});
    tbl.push_back('{0, 0, 1, 1, 0, 13});
    tbl.push_back('{0, 0, 1, 0, 0, 12});
    for (int i = 0; i < 6; i++) tbl.push_back('{0, 0, 1, 1, 0, 10 - 2 * i});
    tbl.push_back('{0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 2});
    tbl.push_back('{1, 1, 1, 0, 0, 3});
    tbl.push_back('{0, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 0});
    foreach (tbl[i]) begin
      stepa(tbl[i].p0, tbl[i].p1, tbl[i].pm, tbl[i].ps, tbl[i].fl);
      chk($sformatf("tbl_count[%0d]", i), count, 64'(tbl[i].exp_count));
    end

    // Streaming push2/pop2 across pointer wrap; popped pcs must be contiguous
    have_last = 1'b0;
    last      = '0;
    for (int i = 0; i < 40; i++) begin
      if (master_valid) begin
        if (have_last) chk("stream_master_pc", master_pc, last + 32'd4);
        last = master_pc; have_last = 1'b1;
        if (slave_valid) begin
          chk("stream_slave_pc", slave_pc, last + 32'd4);
          last = slave_pc;
        end
      end
      stepa(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("stream_count", count, 5'd2);

    // Flush at count 5 beats same-cycle push and pop
    stepa(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    stepa(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_count", count, 5'd5);
    save_pe = perf_empty_cyc;
    save_pf = perf_full_cyc;
    stepa(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_count",      count, 5'd0);
    chk("t6_empty",      fifo_empty, 1'b1);
    chk("t6_perf_empty", perf_empty_cyc, save_pe);
    chk("t6_perf_full",  perf_full_cyc, save_pf);
    stepa(1'b0, 1'b0, 0, 0, 0);

    // Mid-run reset overrides a concurrent push and clears counters
    stepa(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0; push0_valid = 1'b1; push1_valid = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1; push0_valid = 1'b0; push1_valid = 1'b0;
    mq.delete(); m_pe = '0; m_pf = '0;
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
